// File: rtl/ddr2_sys_master_0_bytes_to_packets.sv
// Byte-stream to Avalon-ST packet decoder: strips SOP/EOP/channel markers and
// escape sequences, emitting registered data beats with sop/eop/channel.
module ddr2_sys_master_0_bytes_to_packets #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    input  logic                     out_ready
);

    localparam logic [7:0] SOP_BYTE  = 8'h7A;
    localparam logic [7:0] EOP_BYTE  = 8'h7B;
    localparam logic [7:0] CHAN_BYTE = 8'h7C;
    localparam logic [7:0] ESC_BYTE  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    logic                     esc_r;
    logic                     chan_next_r;
    logic                     pend_sop_r;
    logic                     pend_eop_r;
    logic [CHANNEL_WIDTH-1:0] chan_reg_r;

    logic                     esc_s;
    logic                     chan_next_s;
    logic                     pend_sop_s;
    logic                     pend_eop_s;
    logic [CHANNEL_WIDTH-1:0] chan_reg_s;
    logic                     accept_s;
    logic                     have_val_s;
    logic                     load_s;
    logic [7:0]               value_s;

    // Every byte type, markers included, waits for the output register to free up.
    assign in_ready = !out_valid || out_ready;

    // Byte classification and decoder state update.
    always_comb begin
        accept_s    = in_valid && in_ready;
        esc_s       = esc_r;
        chan_next_s = chan_next_r;
        pend_sop_s  = pend_sop_r;
        pend_eop_s  = pend_eop_r;
        chan_reg_s  = chan_reg_r;
        have_val_s  = 1'b0;
        load_s      = 1'b0;
        value_s     = in_data;

        if (accept_s) begin
            if (esc_r) begin
                // Escaped byte is always a value, even inside a channel sequence.
                value_s    = in_data ^ ESC_XOR;
                esc_s      = 1'b0;
                have_val_s = 1'b1;
            end else if (in_data == ESC_BYTE) begin
                esc_s = 1'b1;
            end else if (chan_next_r) begin
                have_val_s = 1'b1;
            end else begin
                case (in_data)
                    SOP_BYTE: begin
                        pend_sop_s = 1'b1;
                        pend_eop_s = 1'b0;
                    end
                    EOP_BYTE:  pend_eop_s  = 1'b1;
                    CHAN_BYTE: chan_next_s = 1'b1;
                    default:   have_val_s  = 1'b1;
                endcase
            end
        end else begin
            have_val_s = 1'b0;
        end

        if (have_val_s) begin
            if (chan_next_r) begin
                chan_reg_s  = value_s[CHANNEL_WIDTH-1:0];
                chan_next_s = 1'b0;
            end else begin
                load_s     = 1'b1;
                pend_sop_s = 1'b0;
                pend_eop_s = 1'b0;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            esc_r       <= 1'b0;
            chan_next_r <= 1'b0;
            pend_sop_r  <= 1'b0;
            pend_eop_r  <= 1'b0;
            chan_reg_r  <= {CHANNEL_WIDTH{1'b0}};
        end else begin
            esc_r       <= esc_s;
            chan_next_r <= chan_next_s;
            pend_sop_r  <= pend_sop_s;
            pend_eop_r  <= pend_eop_s;
            chan_reg_r  <= chan_reg_s;
        end
    end

    // Output beat register; a new load wins over the handshake clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_data          <= 8'h00;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_channel       <= {CHANNEL_WIDTH{1'b0}};
        end else if (load_s) begin
            out_valid         <= 1'b1;
            out_data          <= value_s;
            out_startofpacket <= pend_sop_r;
            out_endofpacket   <= pend_eop_r;
            out_channel       <= chan_reg_r;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: doc/ddr2_sys_master_0_bytes_to_packets.md
# ddr2_sys_master_0_bytes_to_packets

Byte-stream-to-packet decoder for the DDR2 system debug master, directly downstream of the master's Avalon-ST timing adapter. Consumes the raw 8-bit byte stream and strips the framing protocol: SOP, EOP and channel markers plus escape sequences. Emits an Avalon-ST packet stream with startofpacket, endofpacket and channel to the packet-to-transaction stage. Output is registered; the block applies backpressure upstream through in_ready.

## Interface
- CHANNEL_WIDTH, 8: width of out_channel (1–8); the channel value byte is truncated to its low CHANNEL_WIDTH bits.
- clk  input  1  sole clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- out_valid  output  1  decoded data beat valid.
- out_data  output  8  decoded data byte.
- out_startofpacket  output  1  beat is first of packet.
- out_endofpacket  output  1  beat is last of packet.
- out_channel  output  CHANNEL_WIDTH  channel of beat.
- out_ready  input  1  downstream accepts beat when out_valid && out_ready.

## Operation
- Special bytes: 0x7A SOP marker, 0x7B EOP marker, 0x7C channel marker, 0x7D escape.
- Internal state:
  - esc: an escape byte has been received.
  - chan_next: the next value byte is a channel number.
  - pend_sop and pend_eop: flags for the next data beat.
  - chan_reg: current channel.
- in_ready = !out_valid || out_ready, combinational, applied to every byte type. Marker bytes are consumed on the same condition even though they produce no beat.
- Each accepted byte b is handled by the first matching rule:
  1. esc=1: value v = b ^ 0x20; clear esc; continue at "value handling" with v.
  2. b=0x7D: set esc; no output.
  3. chan_next=1: v = b; go to "value handling".
  4. b=0x7A: set pend_sop; clear pend_eop; no output.
  5. b=0x7B: set pend_eop; no output.
  6. b=0x7C: set chan_next; no output.
  7. Otherwise: v = b; go to "value handling".
- Value handling:
  - If chan_next: chan_reg ← v[CHANNEL_WIDTH-1:0]; clear chan_next; no output.
  - Else: load the output register.
    - out_data ← v.
    - out_startofpacket ← pend_sop.
    - out_endofpacket ← pend_eop.
    - out_channel ← chan_reg, also accounting for a same-cycle channel update, which cannot occur since one byte is handled per cycle.
    - Set out_valid; clear pend_sop and pend_eop.
- Escape inside a channel sequence: 0x7C, 0x7D, X sets channel = X ^ 0x20. Special codes after 0x7C other than 0x7D are literal channel values; 0x7C, 0x7A sets channel 0x7A.
- Output register: when out_valid && out_ready and no new beat is loaded that cycle, clear out_valid. When a new beat loads in the same cycle, keep out_valid high with the new contents.
- While out_valid && !out_ready, all out_* hold stable and no byte is accepted.
- Reset (reset_n low, any time, including mid-escape or mid-packet):
  - out_valid=0, out_data=0x00, out_startofpacket=0, out_endofpacket=0, out_channel=0, in_ready=1 after release.
  - esc=0, chan_next=0, pend_sop=0, pend_eop=0, chan_reg=0.
  - Partial sequences are discarded.

## Timing
- Latency: a data byte accepted at edge N appears on out_* after edge N (valid in cycle N+1).
- Marker, escape and channel bytes cost one accepted cycle each and produce no beat.
- Throughput: one byte per cycle with out_ready held high.
- in_ready deasserts combinationally in the same cycle out_ready drops while out_valid=1.
- No combinational path from in_* to out_*; a combinational path from out_ready to in_ready is permitted.
- Channel is sticky across packets until a new channel sequence arrives.

## Test plan
- Basic packet, out_ready=1: 0x7C,0x03,0x7A,0x11,0x22,0x7B,0x33 produces three beats.
  - 0x11 with sop=1, eop=0.
  - 0x22 with sop=0, eop=0.
  - 0x33 with sop=0, eop=1.
  - All beats carry channel=3, one cycle after acceptance of each data byte.
- Escapes: 0x7A,0x7D,0x5A,0x7B,0x7D,0x5D produces beats 0x7A (sop=1) and 0x7D (eop=1). An escaped channel sequence 0x7C,0x7D,0x5C sets channel=0x7C, truncated to CHANNEL_WIDTH.
- Backpressure: stream 0x7A,0x01,0x02,0x7B,0x03 with out_ready low for 4 cycles after the first beat.
  - Beat 0x01 (sop=1) holds stable throughout.
  - in_ready=0 throughout, and no byte is lost.
  - Final output is exactly 0x01,0x02,0x03 with eop on 0x03.
- Marker interplay: 0x7B,0x7A,0x44 produces a single beat 0x44 with sop=1, eop=0. A duplicate 0x7A,0x7A,0x55 produces a single sop on 0x55.
- Reset mid-sequence: send 0x7C,0x7D, then pulse reset_n low for 1 cycle, then 0x5C,0x66.
  - All outputs read 0 during reset.
  - Beat 0x5C appears with channel=0, followed by beat 0x66; the escape is discarded.
- Random stress: random bytes with 20% special codes under random out_ready, checked against a reference-model decoder for data, sop, eop and channel, with no drops or duplicates.
